data_memory_ctrl: RTL

//   Parametrised MIPS data memory (MEM stage) with synchronous read, byte/half/word

---
 rtl/mem_pkg.sv | 28 ++
 rtl/bytewise_ram.sv | 47 ++++
 rtl/data_memory_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size/state encodings and the alignment rule for the MEM stage
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DUMP  = 2'b01,
    DRAIN = 2'b10
  } dump_state_e;

  // The reserved size code 11 is treated as misaligned so it can never touch the array.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = lane[0];
      MEM_WORD: mis = (lane != 2'b00);
      default:  mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/bytewise_ram.sv
// rtl/bytewise_ram.sv - single-port word RAM with per-lane write enables and registered read
module bytewise_ram #(
  parameter int  NB_DATA   = 32,
  parameter int  RAM_DEPTH = 256,
  localparam int NB_INDEX  = $clog2(RAM_DEPTH),
  localparam int NB_LANES  = NB_DATA / 8
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_read_enable,
  input  logic [NB_LANES-1:0] i_lane_we,
  input  logic [NB_INDEX-1:0] i_index,
  input  logic [NB_DATA-1:0]  i_write_data,
  output logic [NB_DATA-1:0]  o_read_data
);

  logic [NB_DATA-1:0] mem [RAM_DEPTH];
  logic [NB_DATA-1:0] rdata_q, rdata_d;

  // Contents are intentionally never reset; only the read register is.
  always_ff @(posedge i_clock) begin
    for (int l = 0; l < NB_LANES; l++) begin
      if (i_lane_we[l]) begin
        mem[i_index][l*8 +: 8] <= i_write_data[l*8 +: 8];
      end
    end
  end

  // Read-first: a read in the same cycle as a write to that word sees the old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (i_read_enable) begin
      rdata_d = mem[i_index];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_read_data = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - MIPS MEM-stage data memory with lane stores, load extension and dump engine
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int  NB_DATA   = 32,
  parameter int  NB_ADDR   = 32,
  parameter int  RAM_DEPTH = 256,
  localparam int NB_INDEX  = $clog2(RAM_DEPTH)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_valid,
  input  logic                i_read_enable,
  input  logic                i_write_enable,
  input  logic [1:0]          i_mem_size,
  input  logic                i_unsigned,
  input  logic [NB_ADDR-1:0]  i_address,
  input  logic [NB_DATA-1:0]  i_write_data,
  output logic [NB_DATA-1:0]  o_read_data,
  output logic                o_read_valid,
  output logic                o_misaligned,
  output logic                o_busy,
  input  logic                i_dump_start,
  output logic [NB_DATA-1:0]  o_dump_data,
  output logic [NB_INDEX-1:0] o_dump_index,
  output logic                o_dump_valid,
  output logic                o_dump_done
);

  localparam int NB_LANES = NB_DATA / 8;

  dump_state_e         state_q, state_d;
  logic [NB_INDEX-1:0] cnt_q, cnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_mis_q, rd_mis_d;
  logic                mis_q, mis_d;
  logic [1:0]          size_p_q, size_p_d;
  logic [1:0]          lane_p_q, lane_p_d;
  logic                uns_p_q, uns_p_d;
  logic [NB_DATA-1:0]  rd_hold_q, rd_hold_d;
  logic                dump_valid_q, dump_valid_d;
  logic [NB_INDEX-1:0] dump_index_q, dump_index_d;

  logic [1:0]          lane;
  logic [NB_INDEX-1:0] cpu_index;
  logic                busy, cpu_req, mis, do_read, do_write;
  logic [NB_LANES-1:0] lane_we;
  logic [NB_DATA-1:0]  ram_wdata, ram_rdata, ext_data, read_data;
  logic [NB_INDEX-1:0] ram_index;
  logic                ram_re;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic                unused_addr_bits;

  assign lane             = i_address[1:0];
  assign cpu_index        = i_address[NB_INDEX+1:2];
  assign unused_addr_bits = ^i_address[NB_ADDR-1:NB_INDEX+2];

  assign busy     = (state_q != IDLE);
  assign cpu_req  = i_valid && !busy && (i_read_enable || i_write_enable);
  assign mis      = is_misaligned(i_mem_size, lane);
  assign do_read  = cpu_req && i_read_enable && !mis;
  assign do_write = cpu_req && i_write_enable && !mis;

  // Store data is replicated across lanes so the lane enables alone pick the target bytes.
  always_comb begin
    lane_we   = '0;
    ram_wdata = i_write_data;
    case (i_mem_size)
      MEM_BYTE: begin
        lane_we   = NB_LANES'(1) << lane;
        ram_wdata = {NB_LANES{i_write_data[7:0]}};
      end
      MEM_HALF: begin
        lane_we   = NB_LANES'(3) << {lane[1], 1'b0};
        ram_wdata = {(NB_LANES/2){i_write_data[15:0]}};
      end
      MEM_WORD: lane_we = '1;
      default:  lane_we = '0;
    endcase
    if (!do_write) begin
      lane_we = '0;
    end
  end

  assign ram_index = (state_q == DUMP) ? cnt_q : cpu_index;
  assign ram_re    = (state_q == DUMP) || do_read;

  bytewise_ram #(
    .NB_DATA   (NB_DATA),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_ram (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_read_enable (ram_re),
    .i_lane_we     (lane_we),
    .i_index       (ram_index),
    .i_write_data  (ram_wdata),
    .o_read_data   (ram_rdata)
  );

  assign ld_byte = ram_rdata[{lane_p_q, 3'b000} +: 8];
  assign ld_half = ram_rdata[{lane_p_q[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = ram_rdata;
    case (size_p_q)
      MEM_BYTE: ext_data = uns_p_q ? {{(NB_DATA-8){1'b0}}, ld_byte}
                                   : {{(NB_DATA-8){ld_byte[7]}}, ld_byte};
      MEM_HALF: ext_data = uns_p_q ? {{(NB_DATA-16){1'b0}}, ld_half}
                                   : {{(NB_DATA-16){ld_half[15]}}, ld_half};
      default:  ext_data = ram_rdata;
    endcase
  end

  // The RAM register is shared with the dump path, so the load result is held separately.
  always_comb begin
    read_data = rd_hold_q;
    if (rd_valid_q) begin
      read_data = rd_mis_q ? '0 : ext_data;
    end
  end

  always_comb begin
    rd_valid_d = cpu_req && i_read_enable;
    rd_mis_d   = cpu_req && i_read_enable && mis;
    mis_d      = cpu_req && mis;
    size_p_d   = i_mem_size;
    lane_p_d   = lane;
    uns_p_d    = i_unsigned;
    rd_hold_d  = read_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dump_valid_d = (state_q == DUMP);
    dump_index_d = (state_q == DUMP) ? cnt_q : dump_index_q;
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          state_d = DUMP;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        cnt_d = cnt_q + NB_INDEX'(1);
        if (cnt_q == NB_INDEX'(RAM_DEPTH - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_mis_q     <= 1'b0;
      mis_q        <= 1'b0;
      size_p_q     <= 2'b00;
      lane_p_q     <= 2'b00;
      uns_p_q      <= 1'b0;
      rd_hold_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_index_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_mis_q     <= rd_mis_d;
      mis_q        <= mis_d;
      size_p_q     <= size_p_d;
      lane_p_q     <= lane_p_d;
      uns_p_q      <= uns_p_d;
      rd_hold_q    <= rd_hold_d;
      dump_valid_q <= dump_valid_d;
      dump_index_q <= dump_index_d;
    end
  end

  assign o_read_data  = read_data;
  assign o_read_valid = rd_valid_q;
  assign o_misaligned = mis_q;
  assign o_busy       = busy;
  assign o_dump_data  = ram_rdata;
  assign o_dump_index = dump_index_q;
  assign o_dump_valid = dump_valid_q;
  assign o_dump_done  = (state_q == DRAIN);

endmodule
